contrast_frame_ctrl: RTL and testbench
======================================

CONTRAST_FRAME_CTRL -- requirements
Module: contrast_frame_ctrl

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line (1..4095).
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame (1..4095).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port run  input  1  enables frame processing.
REQ-006 The block SHALL have port vsync_in  input  1  frame sync, active high; its rising edge marks a frame start.
REQ-007 The block SHALL have port de_in  input  1  pixel data-enable, high during active pixels.
REQ-008 The block SHALL have port cfg_valid  input  1  configuration offered.
REQ-009 The block SHALL have port cfg_gain  input  3  requested gain numerator; effective gain is cfg_gain/4.
REQ-010 The block SHALL have port cfg_en  input  1  requested contrast enable.
REQ-011 The block SHALL have port cfg_ready  output  1  configuration can be accepted.
REQ-012 The block SHALL have port proc_start  output  1  drives the contrast datapath process-enable.
REQ-013 The block SHALL have port mul_value  output  3  drives the contrast datapath gain.
REQ-014 The block SHALL have port frame_done  output  1  one-cycle pulse at the end of a complete frame.
REQ-015 The block SHALL have port line_err  output  1  sticky line-length error flag.
REQ-016 The block SHALL have port frame_err  output  1  sticky early-vsync error flag.
REQ-017 The block SHALL have port err_clr  input  1  clears line_err and frame_err.
REQ-018 The block SHALL have port frame_cnt  output  16  count of completed frames.

Function
REQ-019 vs_edge SHALL equal vsync_in AND NOT vs_d, where vs_d is vsync_in registered once; de_fall SHALL equal de_d AND NOT de_in.
REQ-020 The FSM SHALL have states IDLE, WAIT_VS, ACTIVE and DONE.
REQ-021 IDLE SHALL go to WAIT_VS when run=1; WAIT_VS SHALL go to IDLE when run=0, else to ACTIVE on vs_edge.
REQ-022 ACTIVE SHALL ignore run, finishing the frame before run is re-examined.
REQ-023 ACTIVE SHALL go to DONE on the de_fall that completes line V_ACTIVE; DONE SHALL last one cycle, then go to WAIT_VS.
REQ-024 In ACTIVE, an 12-bit pixel counter SHALL increment on each cycle with de_in=1 and clear on de_fall.
REQ-025 In ACTIVE, a 12-bit line counter SHALL increment on de_fall; both counters SHALL clear on entry to ACTIVE.
REQ-026 On de_fall in ACTIVE with pixel count not equal to H_ACTIVE, line_err SHALL set, the line SHALL still count, and the frame SHALL continue.
REQ-027 On vs_edge in ACTIVE, frame_err SHALL set, the counters SHALL clear, the FSM SHALL stay in ACTIVE, frame_done SHALL not pulse, and frame_cnt SHALL not increment.
REQ-028 err_clr SHALL clear both sticky flags; a set event in the same cycle SHALL win.
REQ-029 Configuration SHALL use a shadow register: cfg_ready equals NOT pend.
REQ-030 On cfg_valid AND cfg_ready, cfg_gain and cfg_en SHALL be captured into pending registers and pend SHALL set.
REQ-031 On vs_edge, from any state, with pend=1, the pending values SHALL copy to the active registers and pend SHALL clear.
REQ-032 A configuration accepted in the same cycle as vs_edge SHALL apply at the following vs_edge.
REQ-033 mul_value SHALL be the active gain register.
REQ-034 proc_start SHALL be registered and equal 1 exactly when the state is ACTIVE and active_en=1.
REQ-035 proc_start SHALL be high in the cycle after the vs_edge cycle, and active gain and enable SHALL be stable throughout ACTIVE.
REQ-036 frame_done SHALL be high exactly during DONE.
REQ-037 frame_cnt SHALL increment on entry to DONE and wrap from 0xFFFF to 0.

Reset
REQ-038 Asserting rst_n low SHALL immediately set the state to IDLE and clear pend, the counters, proc_start, frame_done, line_err, frame_err, frame_cnt, vs_d and de_d.
REQ-039 Reset SHALL set mul_value to 3'd4 (unity gain) and active_en to 0, so cfg_ready is 1 after reset.
REQ-040 Reset mid-frame SHALL abandon the frame, and the block SHALL wait for a fresh run and vs_edge.

Verification
REQ-041 Scenario: reset, run=1, cfg gain=6/en=1, then a 640x480 frame -> cfg_ready drops to 0 after accept; proc_start=1 from the cycle after vs_edge; mul_value=6; frame_done pulses once; frame_cnt=1.
REQ-042 Scenario: cfg gain=2 accepted mid-frame -> mul_value holds its old value until the next vs_edge, then becomes 2; cfg_ready returns to 1 at that edge.
REQ-043 Scenario: one line of 639 pixels -> line_err=1 and the frame still completes; err_clr -> line_err=0.
REQ-044 Scenario: vsync rising edge after 100 lines -> frame_err=1; no frame_done; the next full frame completes with frame_done.
REQ-045 Scenario: run dropped mid-frame -> the frame completes, the FSM returns to IDLE, and proc_start=0 from DONE onward.
REQ-046 Scenario: frame_cnt preloaded by forcing 65535 frames (or a reduced H_ACTIVE=4/V_ACTIVE=2 run) -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/contrast_frame_ctrl.sv
// Frame-level controller for a contrast datapath.
// Tracks vsync/de timing through a small FSM, double-buffers the gain/enable
// configuration so it only changes at frame boundaries, and reports line-length
// and early-vsync errors plus a completed-frame counter.
module contrast_frame_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic        cfg_valid,
    input  logic [2:0]  cfg_gain,
    input  logic        cfg_en,
    output logic        cfg_ready,
    output logic        proc_start,
    output logic [2:0]  mul_value,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    input  logic        err_clr,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_ACTIVE  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [11:0] H_LEN  = 12'(H_ACTIVE);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE - 1);

    state_t      state_r;
    state_t      state_s;
    logic        vs_d_r;
    logic        de_d_r;
    logic        vs_edge_s;
    logic        de_fall_s;
    logic [11:0] pix_cnt_r;
    logic [11:0] line_cnt_r;
    logic        pend_r;
    logic [2:0]  pend_gain_r;
    logic        pend_en_r;
    logic [2:0]  active_gain_r;
    logic        active_en_r;
    logic        active_en_s;
    logic        proc_start_r;
    logic        proc_start_s;
    logic        frame_done_r;
    logic        frame_done_s;
    logic        line_err_r;
    logic        frame_err_r;
    logic        line_set_s;
    logic        frame_set_s;
    logic [15:0] frame_cnt_r;

    assign vs_edge_s   = vsync_in & ~vs_d_r;
    assign de_fall_s   = de_d_r & ~de_in;
    assign line_set_s  = (state_r == S_ACTIVE) && de_fall_s && (pix_cnt_r != H_LEN);
    assign frame_set_s = (state_r == S_ACTIVE) && vs_edge_s;

    assign cfg_ready  = ~pend_r;
    assign mul_value  = active_gain_r;
    assign proc_start = proc_start_r;
    assign frame_done = frame_done_r;
    assign line_err   = line_err_r;
    assign frame_err  = frame_err_r;
    assign frame_cnt  = frame_cnt_r;

    // Delay vsync and de by one cycle for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d_r <= 1'b0;
            de_d_r <= 1'b0;
        end else begin
            vs_d_r <= vsync_in;
            de_d_r <= de_in;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; an early vsync in ACTIVE restarts the frame in place.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (run) state_s = S_WAIT_VS;
                else     state_s = S_IDLE;
            end
            S_WAIT_VS: begin
                if (!run)          state_s = S_IDLE;
                else if (vs_edge_s) state_s = S_ACTIVE;
                else               state_s = S_WAIT_VS;
            end
            S_ACTIVE: begin
                if (vs_edge_s)                              state_s = S_ACTIVE;
                else if (de_fall_s && (line_cnt_r == V_LAST)) state_s = S_DONE;
                else                                        state_s = S_ACTIVE;
            end
            S_DONE: begin
                state_s = S_WAIT_VS;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // FSM output logic, computed from the next state so outputs can be registered.
    always_comb begin
        if (vs_edge_s && pend_r) active_en_s = pend_en_r;
        else                     active_en_s = active_en_r;
        proc_start_s = (state_s == S_ACTIVE) && active_en_s;
        frame_done_s = (state_s == S_DONE);
    end

    // Registered FSM outputs and completed-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proc_start_r <= 1'b0;
            frame_done_r <= 1'b0;
            frame_cnt_r  <= 16'd0;
        end else begin
            proc_start_r <= proc_start_s;
            frame_done_r <= frame_done_s;
            if ((state_r == S_ACTIVE) && (state_s == S_DONE)) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Pixel and line counters; held at zero outside ACTIVE so entry starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_r  <= 12'd0;
            line_cnt_r <= 12'd0;
        end else if (state_r != S_ACTIVE) begin
            pix_cnt_r  <= 12'd0;
            line_cnt_r <= 12'd0;
        end else if (vs_edge_s) begin
            pix_cnt_r  <= 12'd0;
            line_cnt_r <= 12'd0;
        end else if (de_fall_s) begin
            pix_cnt_r  <= 12'd0;
            line_cnt_r <= line_cnt_r + 12'd1;
        end else if (de_in) begin
            pix_cnt_r  <= pix_cnt_r + 12'd1;
            line_cnt_r <= line_cnt_r;
        end else begin
            pix_cnt_r  <= pix_cnt_r;
            line_cnt_r <= line_cnt_r;
        end
    end

    // Sticky error flags; a new error event takes priority over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_err_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (line_set_s)   line_err_r <= 1'b1;
            else if (err_clr) line_err_r <= 1'b0;
            else              line_err_r <= line_err_r;
            if (frame_set_s)  frame_err_r <= 1'b1;
            else if (err_clr) frame_err_r <= 1'b0;
            else              frame_err_r <= frame_err_r;
        end
    end

    // Shadow configuration: capture when free, promote to active on vsync edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r        <= 1'b0;
            pend_gain_r   <= 3'd0;
            pend_en_r     <= 1'b0;
            active_gain_r <= 3'd4;
            active_en_r   <= 1'b0;
        end else if (vs_edge_s && pend_r) begin
            pend_r        <= 1'b0;
            active_gain_r <= pend_gain_r;
            active_en_r   <= pend_en_r;
        end else if (cfg_valid && !pend_r) begin
            pend_r        <= 1'b1;
            pend_gain_r   <= cfg_gain;
            pend_en_r     <= cfg_en;
        end else begin
            pend_r        <= pend_r;
        end
    end

endmodule

// File: tb/tb_contrast_frame_ctrl.sv
// Directed + randomized bench for contrast_frame_ctrl with a frame-level model.
module tb_contrast_frame_ctrl;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        vsync_in;
    logic        de_in;
    logic        cfg_valid;
    logic [2:0]  cfg_gain;
    logic        cfg_en;
    logic        cfg_ready;
    logic        proc_start;
    logic [2:0]  mul_value;
    logic        frame_done;
    logic        line_err;
    logic        frame_err;
    logic        err_clr;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    // Frame-level reference model
    logic [2:0]  m_mul;
    bit          m_en;
    bit          m_pend;
    logic [2:0]  m_pg;
    bit          m_pe;
    logic [15:0] m_cnt;
    bit          m_lerr;
    bit          m_ferr;
    bit          m_active;
    bit          m_run;
    int          m_lines;
    int          m_done = 0;

    contrast_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .vsync_in(vsync_in), .de_in(de_in),
        .cfg_valid(cfg_valid), .cfg_gain(cfg_gain), .cfg_en(cfg_en),
        .cfg_ready(cfg_ready), .proc_start(proc_start), .mul_value(mul_value),
        .frame_done(frame_done), .line_err(line_err), .frame_err(frame_err),
        .err_clr(err_clr), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_done pulses on the falling edge.
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_pulses <= done_pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mul = 3'd4; m_en = 1'b0; m_pend = 1'b0; m_pg = 3'd0; m_pe = 1'b0;
        m_cnt = 16'd0; m_lerr = 1'b0; m_ferr = 1'b0; m_active = 1'b0; m_lines = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".cfg_ready"},  16'(cfg_ready),   16'(!m_pend));
        chk({tag, ".mul_value"},  16'(mul_value),   16'(m_mul));
        chk({tag, ".proc_start"}, 16'(proc_start),  16'(m_active & m_en));
        chk({tag, ".line_err"},   16'(line_err),    16'(m_lerr));
        chk({tag, ".frame_err"},  16'(frame_err),   16'(m_ferr));
        chk({tag, ".frame_cnt"},  frame_cnt,        m_cnt);
        chk({tag, ".done_count"}, 16'(done_pulses), 16'(m_done));
    endtask

    task automatic do_cfg(input logic [2:0] g, input bit e);
        cfg_valid = 1'b1; cfg_gain = g; cfg_en = e;
        tick();
        cfg_valid = 1'b0;
        if (!m_pend) begin m_pg = g; m_pe = e; m_pend = 1'b1; end
        check_outputs("cfg");
    endtask

    task automatic do_vsync(input bit with_cfg, input logic [2:0] g, input bit e);
        vsync_in = 1'b1; cfg_valid = with_cfg; cfg_gain = g; cfg_en = e;
        tick();
        vsync_in = 1'b0; cfg_valid = 1'b0;
        if (m_pend) begin
            m_mul = m_pg; m_en = m_pe; m_pend = 1'b0;
        end else if (with_cfg) begin
            m_pg = g; m_pe = e; m_pend = 1'b1;
        end
        if (m_active) begin
            m_ferr = 1'b1; m_lines = 0;
        end else if (m_run) begin
            m_active = 1'b1; m_lines = 0;
        end
        check_outputs("vsync");
        tick();
    endtask

    task automatic send_line(input int n, input bit clr);
        bit just_done;
        bit set;
        just_done = 1'b0;
        set = 1'b0;
        de_in = 1'b1;
        repeat (n) tick();
        de_in = 1'b0; err_clr = clr;
        tick();
        err_clr = 1'b0;
        if (m_active) begin
            if (n != H) set = 1'b1;
            m_lines++;
            if (m_lines == V) begin
                m_active = 1'b0; m_cnt = m_cnt + 16'd1; m_done++; just_done = 1'b1;
            end
        end
        if (set) m_lerr = 1'b1;
        else if (clr) m_lerr = 1'b0;
        if (clr) m_ferr = 1'b0;
        chk("frame_done_at_fall", 16'(frame_done), 16'(just_done));
        repeat ($urandom_range(2, 4)) tick();
        check_outputs("line");
    endtask

    task automatic full_frame(input int short_idx);
        for (int l = 0; l < V; l++) send_line((l == short_idx) ? H - 1 : H, 1'b0);
    endtask

    task automatic do_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_lerr = 1'b0; m_ferr = 1'b0;
        check_outputs("err_clr");
    endtask

    task automatic async_reset();
        vsync_in = 1'b0; de_in = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        chk("async_reset.frame_done", 16'(frame_done), 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [2:0] g;
        bit e;
        int si;
        rst_n = 1'b0; run = 1'b0; vsync_in = 1'b0; de_in = 1'b0;
        cfg_valid = 1'b0; cfg_gain = 3'd0; cfg_en = 1'b0; err_clr = 1'b0;
        m_run = 1'b0;
        model_reset();
        repeat (2) tick();
        check_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic frame with gain 6
        run = 1'b1; m_run = 1'b1;
        tick(); tick();
        do_cfg(3'd6, 1'b1);
        do_vsync(1'b0, 3'd0, 1'b0);
        full_frame(-1);

        // Mid-frame configuration waits for next vsync
        do_vsync(1'b0, 3'd0, 1'b0);
        send_line(H, 1'b0);
        do_cfg(3'd2, 1'b1);
        for (int l = 1; l < V; l++) send_line(H, 1'b0);
        do_vsync(1'b0, 3'd0, 1'b0);
        full_frame(-1);

        // Short line sets line_err, frame still completes
        do_vsync(1'b0, 3'd0, 1'b0);
        full_frame(1);
        do_clr();

        // Error set in same cycle as err_clr wins
        do_vsync(1'b0, 3'd0, 1'b0);
        send_line(H, 1'b0);
        send_line(H - 1, 1'b1);
        send_line(H, 1'b0);
        send_line(H, 1'b0);
        do_clr();

        // Early vsync after two lines
        do_vsync(1'b0, 3'd0, 1'b0);
        send_line(H, 1'b0);
        send_line(H, 1'b0);
        do_vsync(1'b0, 3'd0, 1'b0);
        full_frame(-1);
        do_clr();

        // Configuration accepted on the vsync edge applies one frame later
        do_vsync(1'b1, 3'd5, 1'b1);
        full_frame(-1);
        do_vsync(1'b0, 3'd0, 1'b0);
        full_frame(-1);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            g = 3'($urandom_range(0, 7));
            e = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) do_cfg(g, e);
            si = -1;
            if ($urandom_range(0, 1) == 1) si = int'($urandom_range(0, V - 1));
            do_vsync(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1);
            full_frame(si);
            if ($urandom_range(0, 1) == 1) do_clr();
        end

        // Run dropped mid-frame: frame finishes, then block goes idle
        do_cfg(3'd3, 1'b1);
        do_vsync(1'b0, 3'd0, 1'b0);
        send_line(H, 1'b0);
        run = 1'b0; m_run = 1'b0;
        for (int l = 1; l < V; l++) send_line(H, 1'b0);
        do_vsync(1'b0, 3'd0, 1'b0);
        full_frame(-1);
        run = 1'b1; m_run = 1'b1;
        tick(); tick();

        // Reset mid-frame abandons the frame
        do_vsync(1'b0, 3'd0, 1'b0);
        send_line(H, 1'b0);
        send_line(H, 1'b0);
        async_reset();
        tick();
        send_line(H, 1'b0);
        do_vsync(1'b0, 3'd0, 1'b0);
        full_frame(-1);

        // Frame counter wrap
        force dut.frame_cnt_r = 16'hFFFF;
        tick();
        release dut.frame_cnt_r;
        m_cnt = 16'hFFFF;
        check_outputs("preload");
        do_vsync(1'b0, 3'd0, 1'b0);
        full_frame(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
